sort_floats_seq: RTL and testbench

Sequential, handshaked sorter for three FLEN-bit floating-point values. It accepts an unsorted triple over a valid/ready input channel and sorts it in three compare-swap steps through one time-shared `f_less_or_equal` instance. It then presents the sorted triple on a valid/ready output channel. It is the area-lean, streaming counterpart of the zero-latency three-comparator sorter, and sits between FP producers and consumers that tolerate latency.

---
 rtl/sort_floats_seq_pkg.sv | 22 ++
 rtl/sort_floats_seq_float_cmp_swap.sv | 77 +++++++
 rtl/sort_floats_seq.sv | 137 +++++++++++++
 tb/tb_sort_floats_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_floats_seq_pkg.sv
// Shared types and constants for the sequential three-float sorter.
// Optional feature macro: SORT_FLOATS_SEQ_PERM_EN (adds permutation tracking).
package sort_floats_seq_pkg;

  // Float width shared with the rest of the FP datapath.
  localparam int FLEN = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP1 = 3'd1,
    STEP2 = 3'd2,
    STEP3 = 3'd3,
    OUT   = 3'd4
  } state_t;

  typedef logic [0:2][FLEN-1:0] triple_t;
  typedef logic [0:2][1:0]      perm_t;

  // Slot i initially holds input index i.
  localparam perm_t PERM_IDENTITY = {2'd0, 2'd1, 2'd2};

endpackage

// File: rtl/sort_floats_seq_float_cmp_swap.sv
// Compare-swap element: one f_less_or_equal comparator plus the lo/hi
// steering of the operand pair and its index tags.
module f_less_or_equal #(
  parameter int FLEN = 64
) (
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  output logic            res,
  output logic            err
);

  localparam int EW = (FLEN == 64) ? 11 : (FLEN == 32) ? 8 : 5;
  localparam int MW = FLEN - 1 - EW;

  logic a_nan, b_nan;
  logic a_sign, b_sign;
  logic [FLEN-2:0] a_mag, b_mag;

  assign a_sign = a[FLEN-1];
  assign b_sign = b[FLEN-1];
  assign a_mag  = a[FLEN-2:0];
  assign b_mag  = b[FLEN-2:0];
  assign a_nan  = (&a[FLEN-2 -: EW]) & (|a[MW-1:0]);
  assign b_nan  = (&b[FLEN-2 -: EW]) & (|b[MW-1:0]);

  // Sign-magnitude ordering; any NaN makes the compare unordered (res=0)
  // and raises err. +0 and -0 compare equal.
  always_comb begin
    err = a_nan | b_nan;
    res = 1'b0;
    if (err) begin
      res = 1'b0;
    end else if ((a_mag == '0) && (b_mag == '0)) begin
      res = 1'b1;
    end else if (a_sign != b_sign) begin
      res = a_sign;
    end else if (!a_sign) begin
      res = (a_mag <= b_mag);
    end else begin
      res = (a_mag >= b_mag);
    end
  end

endmodule

module float_cmp_swap
  import sort_floats_seq_pkg::*;
(
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  input  logic [1:0]      tag_a,
  input  logic [1:0]      tag_b,
  output logic [FLEN-1:0] lo,
  output logic [FLEN-1:0] hi,
  output logic [1:0]      tag_lo,
  output logic [1:0]      tag_hi,
  output logic            err
);

  logic res;

  f_less_or_equal #(.FLEN(FLEN)) u_le (
    .a   (a),
    .b   (b),
    .res (res),
    .err (err)
  );

  // res=1 keeps the pair in place, so equal values stay in input order.
  always_comb begin
    lo     = res ? a : b;
    hi     = res ? b : a;
    tag_lo = res ? tag_a : tag_b;
    tag_hi = res ? tag_b : tag_a;
  end

endmodule

// File: rtl/sort_floats_seq.sv
// Sequential valid/ready sorter for three floats using one time-shared
// compare-swap over three steps. Optional macro SORT_FLOATS_SEQ_PERM_EN
// adds perm registers and the down_perm port.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high; a producer holding valid keeps its data stable until ready.
module sort_floats_seq
  import sort_floats_seq_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    up_valid,
  output logic    up_ready,
  input  triple_t up_data,
  output logic    down_valid,
  input  logic    down_ready,
  output triple_t down_data,
  output logic    down_err,
  output state_t  state_dbg
`ifdef SORT_FLOATS_SEQ_PERM_EN
  ,
  output perm_t   down_perm
`endif
);

  state_t          state, state_nxt;
  triple_t         w;
  logic            err_acc;
  logic            accept, step;
  logic [FLEN-1:0] op_a, op_b, lo, hi;
  logic [1:0]      tag_a, tag_b, tag_lo, tag_hi;
  logic            cmp_err;
  perm_t           perm;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; OUT hands straight to STEP1 when a new triple is waiting
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (up_valid) state_nxt = STEP1;
      STEP1:   state_nxt = STEP2;
      STEP2:   state_nxt = STEP3;
      STEP3:   state_nxt = OUT;
      OUT:     if (down_ready) state_nxt = up_valid ? STEP1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode from state
  always_comb begin
    up_ready   = (state == IDLE) | ((state == OUT) & down_ready);
    down_valid = (state == OUT);
    accept     = up_valid & up_ready;
    step       = (state == STEP1) | (state == STEP2) | (state == STEP3);
  end

  // Operand mux: STEP2 works on slots 1/2, STEP1 and STEP3 on slots 0/1
  always_comb begin
    if (state == STEP2) begin
      op_a  = w[1];
      op_b  = w[2];
      tag_a = perm[1];
      tag_b = perm[2];
    end else begin
      op_a  = w[0];
      op_b  = w[1];
      tag_a = perm[0];
      tag_b = perm[1];
    end
  end

  float_cmp_swap u_cmp (
    .a      (op_a),
    .b      (op_b),
    .tag_a  (tag_a),
    .tag_b  (tag_b),
    .lo     (lo),
    .hi     (hi),
    .tag_lo (tag_lo),
    .tag_hi (tag_hi),
    .err    (cmp_err)
  );

  // Working registers and error accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w       <= '0;
      err_acc <= 1'b0;
    end else if (accept) begin
      w       <= up_data;
      err_acc <= 1'b0;
    end else if (step) begin
      err_acc <= err_acc | cmp_err;
      if (state == STEP2) begin
        w[1] <= lo;
        w[2] <= hi;
      end else begin
        w[0] <= lo;
        w[1] <= hi;
      end
    end
  end

`ifdef SORT_FLOATS_SEQ_PERM_EN
  // Permutation registers follow the data swaps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perm <= '0;
    end else if (accept) begin
      perm <= PERM_IDENTITY;
    end else if (step) begin
      if (state == STEP2) begin
        perm[1] <= tag_lo;
        perm[2] <= tag_hi;
      end else begin
        perm[0] <= tag_lo;
        perm[1] <= tag_hi;
      end
    end
  end

  assign down_perm = perm;
`else
  // Without permutation tracking the tag path carries constants only.
  assign perm = PERM_IDENTITY;
`endif

  assign down_data = w;
  assign down_err  = err_acc;
  assign state_dbg = state;

endmodule

// File: tb/tb_sort_floats_seq.sv
// Self-checking bench for sort_floats_seq: directed vector table, stall /
// bypass / NaN / mid-sort reset sequences, and a randomized stream checked
// against a stable-sort reference model.
module tb_sort_floats_seq;
  import sort_floats_seq_pkg::*;

  localparam logic [63:0] F1   = 64'h3FF0000000000000;
  localparam logic [63:0] F2   = 64'h4000000000000000;
  localparam logic [63:0] F3   = 64'h4008000000000000;
  localparam logic [63:0] FNAN = 64'h7FF8000000000000;
  localparam logic [63:0] FM1  = 64'hBFF0000000000000;
  localparam logic [63:0] FM2  = 64'hC000000000000000;
  localparam logic [63:0] FZ   = 64'h0000000000000000;
  localparam logic [63:0] FNZ  = 64'h8000000000000000;

  logic    clk, rst;
  logic    up_valid, up_ready, down_valid, down_ready, down_err;
  triple_t up_data, down_data;
  state_t  state_dbg;
`ifdef SORT_FLOATS_SEQ_PERM_EN
  perm_t   down_perm;
`endif

  int checks   = 0;
  int failures = 0;

  sort_floats_seq dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_err   (down_err),
    .state_dbg  (state_dbg)
`ifdef SORT_FLOATS_SEQ_PERM_EN
    ,
    .down_perm  (down_perm)
`endif
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_perm(input string name, input perm_t exp);
`ifdef SORT_FLOATS_SEQ_PERM_EN
    check(name, 192'(down_perm), 192'(exp));
`else
    if (exp === 6'bx) $display("unreachable");
`endif
  endtask

  // Reference: stable ascending sort on real values, tracking original index.
  function automatic void model(input triple_t din, output triple_t dout, output perm_t pout);
    real v[3];
    int  idx[3];
    int  t;
    for (int i = 0; i < 3; i++) begin
      v[i]   = $bitstoreal(din[i]);
      idx[i] = i;
    end
    for (int i = 1; i < 3; i++) begin
      for (int j = i; j > 0; j--) begin
        if (v[idx[j-1]] > v[idx[j]]) begin
          t = idx[j-1]; idx[j-1] = idx[j]; idx[j] = t;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      dout[i] = din[idx[i]];
      pout[i] = 2'(idx[i]);
    end
  endfunction

  function automatic triple_t rand_triple();
    triple_t r;
    for (int i = 0; i < 3; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r[i] = {1'($urandom_range(0, 1)), 11'($urandom_range(0, 2046)),
                20'($urandom), 32'($urandom)};
      end else begin
        r[i] = $realtobits(real'(int'($urandom_range(0, 8)) - 4));
      end
    end
    return r;
  endfunction

  // Driver: send one triple with down_ready high, check latency and result.
  task automatic run_vec(input triple_t din, input triple_t dexp, input perm_t pexp,
                         input logic eexp);
    int n;
    @(negedge clk);
    up_data    = din;
    up_valid   = 1'b1;
    down_ready = 1'b1;
    n = 0;
    while (!up_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("up_ready_wait", 192'(up_ready), 192'(1));
    @(negedge clk);
    up_valid = 1'b0;
    n = 1;
    while (!down_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency_negedges", 192'(n), 192'(4));
    check("vec_data", down_data, dexp);
    check("vec_err", 192'(down_err), 192'(eexp));
    check_perm("vec_perm", pexp);
  endtask

  typedef struct {
    triple_t din;
    triple_t dexp;
    perm_t   pexp;
    logic    eexp;
  } vec_t;

  vec_t    vecs[7];
  triple_t exp_q[$];

  initial begin
    triple_t held, pop_in, m_d;
    perm_t   m_p;
    int      n, sent, recv, cyc;
    bit      seen, acc_last;

    rst        = 1'b1;
    up_valid   = 1'b0;
    down_ready = 1'b0;
    up_data    = '0;

    vecs[0] = '{{F3, F1, F2},   {F1, F2, F3},   {2'd1, 2'd2, 2'd0}, 1'b0};
    vecs[1] = '{{F1, F2, F2},   {F1, F2, F2},   {2'd0, 2'd1, 2'd2}, 1'b0};
    vecs[2] = '{{F2, F2, F1},   {F1, F2, F2},   {2'd2, 2'd0, 2'd1}, 1'b0};
    vecs[3] = '{{FNAN, F1, F2}, {F1, F2, FNAN}, {2'd1, 2'd2, 2'd0}, 1'b1};
    vecs[4] = '{{F2, F1, F3},   {F1, F2, F3},   {2'd1, 2'd0, 2'd2}, 1'b0};
    vecs[5] = '{{FM1, FZ, FM2}, {FM2, FM1, FZ}, {2'd2, 2'd0, 2'd1}, 1'b0};
    vecs[6] = '{{FZ, FNZ, F1},  {FZ, FNZ, F1},  {2'd0, 2'd1, 2'd2}, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_down_valid", 192'(down_valid), 192'(0));
    check("rst_up_ready", 192'(up_ready), 192'(1));
    check("rst_down_data", down_data, 192'(0));
    check("rst_down_err", 192'(down_err), 192'(0));
    check_perm("rst_perm", 6'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i].din, vecs[i].dexp, vecs[i].pexp, vecs[i].eexp);
    end

    // Stall in OUT for 5 cycles, then release with a new triple (bypass)
    @(negedge clk);
    up_data    = {F3, F2, F1};
    up_valid   = 1'b1;
    down_ready = 1'b0;
    @(negedge clk);
    up_valid = 1'b0;
    n = 1;
    while (!down_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    held = down_data;
    check("stall_first_data", held, {F1, F2, F3});
    check_perm("stall_first_perm", {2'd2, 2'd1, 2'd0});
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 192'(down_valid), 192'(1));
      check("stall_up_ready", 192'(up_ready), 192'(0));
      check("stall_data_stable", down_data, held);
      @(negedge clk);
    end
    down_ready = 1'b1;
    up_valid   = 1'b1;
    up_data    = {F2, F3, F1};
    #1;
    check("bypass_up_ready", 192'(up_ready), 192'(1));
    @(negedge clk);
    up_valid = 1'b0;
    check("bypass_in_step1", 192'(state_dbg), 192'(STEP1));
    check("bypass_valid_low", 192'(down_valid), 192'(0));
    n = 1;
    while (!down_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bypass_latency", 192'(n), 192'(4));
    check("bypass_data", down_data, {F1, F2, F3});
    check_perm("bypass_perm", {2'd2, 2'd0, 2'd1});

    // Reset during STEP2
    @(negedge clk);
    up_data  = {F3, F1, F2};
    up_valid = 1'b1;
    @(negedge clk);
    up_valid = 1'b0;
    @(negedge clk);
    check("mid_state_step2", 192'(state_dbg), 192'(STEP2));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 192'(down_valid), 192'(0));
    check("mid_rst_up_ready", 192'(up_ready), 192'(1));
    check("mid_rst_data", down_data, 192'(0));
    check("mid_rst_err", 192'(down_err), 192'(0));
    check_perm("mid_rst_perm", 6'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (down_valid) seen = 1'b1;
    end
    check("no_stale_output", 192'(seen), 192'(0));

    // Random stream with random backpressure
    sent = 0; recv = 0; cyc = 0; acc_last = 1'b0;
    while (recv < 100 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (acc_last) begin
        up_valid = 1'b0;
        acc_last = 1'b0;
      end
      if (!up_valid && sent < 100 && $urandom_range(0, 7) != 0) begin
        up_data  = rand_triple();
        up_valid = 1'b1;
      end
      down_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (up_valid && up_ready) begin
        exp_q.push_back(up_data);
        sent++;
        acc_last = 1'b1;
      end
      if (down_valid && down_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_output", 192'(1), 192'(0));
        end else begin
          pop_in = exp_q.pop_front();
          model(pop_in, m_d, m_p);
          check("rand_data", down_data, m_d);
          check("rand_err", 192'(down_err), 192'(0));
          check_perm("rand_perm", m_p);
        end
        recv++;
      end
    end
    up_valid   = 1'b0;
    down_ready = 1'b0;
    check("rand_received", 192'(recv), 192'(100));
    check("rand_queue_empty", 192'(exp_q.size()), 192'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
